data_mem_pipe: RTL and testbench

//  Parametrised successor of the single-cycle data memory: byte-addressable, big-endian word store

---
 rtl/data_mem_pipe.sv | 135 +++++++++++++
 tb/tb_data_mem_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Byte-addressable big-endian data memory with a valid/ready request port and a fixed read latency.
// Clears itself word by word after reset; optional error reporting is enabled by DMEM_ERR_EN.
module data_mem_pipe #(
  parameter int WORD_LEN    = 32,
  parameter int CELL_SIZE   = 8,
  parameter int DEPTH_BYTES = 2048,
  parameter int BASE_ADDR   = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic                              req_write,
  input  logic [WORD_LEN-1:0]               req_addr,
  input  logic [WORD_LEN-1:0]               req_wdata,
  input  logic [WORD_LEN/CELL_SIZE-1:0]     req_be,
  output logic                              rsp_valid,
  output logic [WORD_LEN-1:0]               rsp_rdata,
  output logic                              rsp_err
);

  localparam int NB    = WORD_LEN / CELL_SIZE;
  localparam int OFF_W = $clog2(NB);
  localparam int WORDS = DEPTH_BYTES / NB;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [WORD_LEN-1:0] BASE     = WORD_LEN'(BASE_ADDR);
  localparam logic [WORD_LEN-1:0] SPAN     = WORD_LEN'(DEPTH_BYTES);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(WORDS - 1);

  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t              state, state_next;
  logic [IDX_W-1:0]    clr_cnt, clr_cnt_next;
  logic [WORD_LEN-1:0] mem [WORDS];

  logic [WORD_LEN-1:0] off;
  logic [IDX_W-1:0]    idx;
  logic                in_win;
  logic                accept;
  logic                bad;
  logic                ok;
  logic                do_store;
  logic [WORD_LEN-1:0] load_data;

  logic [RD_LAT-1:0]   pipe_v;
  logic [RD_LAT-1:0]   pipe_e;
  logic [WORD_LEN-1:0] pipe_d [RD_LAT];

  // Handshake: a request transfers on a rising edge where req_valid and req_ready are both 1;
  // every transfer yields exactly one rsp_valid pulse RD_LAT cycles later, with no backpressure.
  assign req_ready = (state == ST_READY);
  assign accept    = req_valid && req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_INIT;
      clr_cnt <= '0;
    end else begin
      state   <= state_next;
      clr_cnt <= clr_cnt_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_cnt_next = clr_cnt;
    case (state)
      ST_INIT: begin
        clr_cnt_next = clr_cnt + 1'b1;
        if (clr_cnt == LAST_IDX) begin
          state_next   = ST_READY;
          clr_cnt_next = '0;
        end
      end
      ST_READY: state_next = ST_READY;
      default:  state_next = ST_INIT;
    endcase
  end

  always_comb begin
    off    = req_addr - BASE;
    in_win = (req_addr >= BASE) && (off < SPAN);
    // Word index drops the low byte bits, so misaligned addresses round down.
    idx    = off[OFF_W +: IDX_W];
  end

`ifdef DMEM_ERR_EN
  logic aligned;
  assign aligned = (off[OFF_W-1:0] == '0);
  assign bad     = !in_win || !aligned;
  assign ok      = !bad;
`else
  assign bad = 1'b0;
  assign ok  = in_win;
`endif

  assign do_store  = accept && req_write && ok;
  assign load_data = (accept && !req_write && ok) ? mem[idx] : '0;

  // The array has no reset; the INIT walk clears it one word per cycle instead.
  always_ff @(posedge clk) begin
    if (state == ST_INIT) begin
      mem[clr_cnt] <= '0;
    end else if (do_store) begin
      for (int i = 0; i < NB; i++) begin
        if (req_be[i]) mem[idx][i*CELL_SIZE +: CELL_SIZE] <= req_wdata[i*CELL_SIZE +: CELL_SIZE];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_v <= '0;
      pipe_e <= '0;
      for (int i = 0; i < RD_LAT; i++) pipe_d[i] <= '0;
    end else begin
      pipe_v[0] <= accept;
      pipe_e[0] <= accept && bad;
      pipe_d[0] <= load_data;
      for (int i = 1; i < RD_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_e[i] <= pipe_e[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  // Idle slots carry zero data and no error, so outputs are 0 whenever rsp_valid is 0.
  assign rsp_valid = pipe_v[RD_LAT-1];
  assign rsp_rdata = pipe_d[RD_LAT-1];
  assign rsp_err   = pipe_e[RD_LAT-1];

endmodule

// File: tb/tb_data_mem_pipe.sv
// Bench for data_mem_pipe: directed vector table plus random traffic against a byte-array model.
// Expectations follow the DMEM_ERR_EN setting of the build.
module tb_data_mem_pipe;

  localparam int WL = 32;
  localparam int CS = 8;
  localparam int DB = 2048;
  localparam int BA = 1024;
  localparam int RL = 3;
  localparam int NB = WL / CS;
  localparam int WORDS = DB / NB;
`ifdef DMEM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [WL-1:0] req_addr = '0;
  logic [WL-1:0] req_wdata = '0;
  logic [NB-1:0] req_be = '0;
  logic          rsp_valid;
  logic [WL-1:0] rsp_rdata;
  logic          rsp_err;

  data_mem_pipe #(
    .WORD_LEN(WL), .CELL_SIZE(CS), .DEPTH_BYTES(DB), .BASE_ADDR(BA), .RD_LAT(RL)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [WL-1:0] exp_q[$];
  logic          exp_err_q[$];
  int            exp_due_q[$];
  logic [7:0]    ref_mem [DB];

  typedef struct {
    bit            wr;
    logic [WL-1:0] addr;
    logic [WL-1:0] wd;
    logic [NB-1:0] be;
    logic [WL-1:0] xd;
    bit            xe;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [WL-1:0] act, input logic [WL-1:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: byte array indexed by address - BASE, lowest address holds the MSB byte.
  function automatic void model(input bit wr, input logic [WL-1:0] addr, input logic [WL-1:0] wd,
                                input logic [NB-1:0] be, output logic [WL-1:0] rd, output bit er);
    int base;
    bit in_win = (addr >= BA) && (addr < BA + DB);
    bit aligned = (addr % NB) == 0;
    rd = '0;
    er = 1'b0;
    if (ERR && (!in_win || !aligned)) begin
      er = 1'b1;
      return;
    end
    if (!in_win) return;
    base = ((int'(addr) - BA) / NB) * NB;
    for (int k = 0; k < NB; k++) begin
      if (wr) begin
        if (be[NB-1-k]) ref_mem[base+k] = wd[WL-1-8*k -: 8];
      end else begin
        rd[WL-1-8*k -: 8] = ref_mem[base+k];
      end
    end
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
        check("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        check("rsp_rdata", rsp_rdata, exp_q[0]);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err_q[0]});
        void'(exp_q.pop_front());
        void'(exp_err_q.pop_front());
        void'(exp_due_q.pop_front());
      end else begin
        check("idle_valid", {31'b0, rsp_valid}, 32'd0);
        check("idle_data_err", rsp_rdata | {31'b0, rsp_err}, 32'd0);
      end
    end
  end

  // driver tasks
  task automatic send(input bit wr, input logic [WL-1:0] addr, input logic [WL-1:0] wd,
                      input logic [NB-1:0] be, input bit use_exp, input logic [WL-1:0] xd, input bit xe);
    logic [WL-1:0] md;
    bit me;
    int n;
    int waitc = 0;
    @(negedge clk);
    while (!req_ready) begin
      waitc++;
      if (waitc > WORDS + 10) begin
        check("ready_timeout", {31'b0, req_ready}, 32'd1);
        return;
      end
      @(negedge clk);
    end
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wd;
    req_be    = be;
    n = cyc;
    @(posedge clk);
    #1 req_valid = 1'b0;
    model(wr, addr, wd, be, md, me);
    exp_q.push_back(use_exp ? xd : md);
    exp_err_q.push_back(use_exp ? xe : me);
    exp_due_q.push_back(n + RL);
  endtask

  task automatic do_reset(input int hold);
    @(negedge clk);
    rst = 1'b1;
    req_valid = 1'b0;
    exp_q.delete();
    exp_err_q.delete();
    exp_due_q.delete();
    repeat (hold) @(negedge clk);
    rst = 1'b0;
    foreach (ref_mem[i]) ref_mem[i] = 8'h00;
  endtask

  task automatic wait_init();
    int early = 0;
    for (int k = 1; k <= WORDS; k++) begin
      @(negedge clk);
      if (k < WORDS && req_ready) early++;
    end
    check("init_ready_low", early, 32'd0);
    check("init_ready_high", {31'b0, req_ready}, 32'd1);
  endtask

  task automatic drain();
    int w = 0;
    while (exp_due_q.size() > 0 && w < RL + 20) begin
      @(negedge clk);
      w++;
    end
    check("drain_timeout", exp_due_q.size(), 32'd0);
  endtask

  initial begin
    int r;
    logic [WL-1:0] a;

    do_reset(3);
    wait_init();

    // reset pulse in the middle of INIT restarts the full clear
    do_reset(2);
    repeat (100) @(negedge clk);
    check("mid_init_ready", {31'b0, req_ready}, 32'd0);
    do_reset(3);
    wait_init();

    vecs.push_back('{1'b1, 32'd1024, 32'hDEADBEEF, 4'hF, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'd1024, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b1, 32'd1028, 32'h11223344, 4'h5, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'd1028, 32'h0, 4'h0, 32'h00220044, 1'b0});
    vecs.push_back('{1'b0, 32'd1024, 32'h0, 4'h0, 32'hDEADBEEF, 1'b0});
    vecs.push_back('{1'b0, 32'd1028, 32'h0, 4'h0, 32'h00220044, 1'b0});
    vecs.push_back('{1'b0, 32'd1032, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'd1000, 32'h0, 4'h0, 32'h0, ERR});
    vecs.push_back('{1'b0, 32'd1026, 32'h0, 4'h0, ERR ? 32'h0 : 32'hDEADBEEF, ERR});
    vecs.push_back('{1'b1, 32'd1026, 32'hAABBCCDD, 4'hF, 32'h0, ERR});
    vecs.push_back('{1'b0, 32'd1024, 32'h0, 4'h0, ERR ? 32'hDEADBEEF : 32'hAABBCCDD, 1'b0});
    vecs.push_back('{1'b1, 32'd3072, 32'hFFFFFFFF, 4'hF, 32'h0, ERR});
    vecs.push_back('{1'b0, 32'd3068, 32'h0, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'd1024, 32'h0, 4'h0, ERR ? 32'hDEADBEEF : 32'hAABBCCDD, 1'b0});
    vecs.push_back('{1'b1, 32'd3068, 32'h12345678, 4'h8, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'd3068, 32'h0, 4'h0, 32'h12000000, 1'b0});
    vecs.push_back('{1'b1, 32'd1032, 32'hFFFFFFFF, 4'h0, 32'h0, 1'b0});
    vecs.push_back('{1'b0, 32'd1032, 32'h0, 4'h0, 32'h0, 1'b0});
    foreach (vecs[i]) send(vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].be, 1'b1, vecs[i].xd, vecs[i].xe);
    drain();

    // random traffic, mostly in a small hot region so loads hit earlier stores
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 7)       a = BA + NB * $urandom_range(0, 15);
      else if (r == 7) a = BA + $urandom_range(0, 63);
      else if (r == 8) a = $urandom_range(0, BA - 1);
      else             a = BA + DB - 8 + $urandom_range(0, 40);
      send(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), 1'b0, '0, 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    // a store in flight at reset is dropped and the word reads back cleared
    send(1'b1, 32'd1024, 32'hDEADBEEF, 4'hF, 1'b1, 32'h0, 1'b0);
    do_reset(2);
    wait_init();
    send(1'b0, 32'd1024, 32'h0, 4'h0, 1'b1, 32'h0, 1'b0);
    drain();
    repeat (RL + 2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
